// File: rtl/matrix_pkg.sv
// Shared types and constants for the scrolling-glyph scheduler.
package matrix_pkg;

  localparam int CHAR_W     = 1;  // glyph code width ('0' / '1')
  localparam int SHIFT_W    = 3;  // scroll step width, steps 0..7
  localparam int NUM_GLYPHS = 2;  // glyphs addressable by CHAR_W bits

  localparam logic [SHIFT_W-1:0] LAST_SHIFT = 3'd7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_e;

endpackage

// File: rtl/matrix_char_fifo.sv
// Synchronous character FIFO with level output.
// A pop on an empty FIFO and a push on a full one are ignored.
// The read port is combinational so that a pop loads the head entry
// straight into the caller's register on the same edge.
module matrix_char_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 1,
  localparam int LVL_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  input  logic             pop_i,
  output logic [W-1:0]     data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);
  import matrix_pkg::*;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/matrix_scroll_sched.sv
// Scroll scheduler for the 8x8 LED-matrix streamer: buffers glyph codes,
// issues one frame command per scroll step and paces frames with a gap.
module matrix_scroll_sched #(
  parameter  int FIFO_DEPTH = 4,
  parameter  int CHAR_W     = matrix_pkg::CHAR_W,
  parameter  int FRAME_GAP  = 64,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1),
  localparam int GAP_W      = $clog2(FRAME_GAP + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         char_valid,
  input  logic [CHAR_W-1:0]            char_data,
  output logic                         char_ready,
  input  logic                         pause,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  input  logic                         frame_done,
  output logic [CHAR_W-1:0]            frame_left,
  output logic [CHAR_W-1:0]            frame_right,
  output logic [matrix_pkg::SHIFT_W-1:0] frame_shift,
  output logic                         frame_blank_left,
  output logic                         busy,
  output logic [LVL_W-1:0]             fifo_level
);
  import matrix_pkg::*;

  state_e             state_q, state_d;
  logic [CHAR_W-1:0]  left_q, left_d;
  logic [CHAR_W-1:0]  right_q, right_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               blank_q, blank_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CHAR_W-1:0]  fifo_dout;

  // No bypass: a full FIFO refuses a push even if it pops on the same edge.
  assign char_ready = !fifo_full;

  matrix_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CHAR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (char_valid && char_ready),
    .data_i  (char_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // State register together with the frame fields and gap counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      left_q  <= '0;
      right_q <= '0;
      shift_q <= '0;
      blank_q <= 1'b1;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      right_q <= right_d;
      shift_q <= shift_d;
      blank_q <= blank_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state and frame-field update; pops happen only when a new glyph
  // enters from the right (leaving IDLE or finishing step 7 in GAP).
  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    right_d  = right_q;
    shift_d  = shift_q;
    blank_d  = blank_q;
    gap_d    = gap_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          right_d  = fifo_dout;
          shift_d  = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (frame_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (frame_done) begin
          gap_d   = GAP_W'(FRAME_GAP - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (!pause) begin
          if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
          end else if (shift_q != LAST_SHIFT) begin
            shift_d = shift_q + 1'b1;
            state_d = ISSUE;
          end else begin
            // Incoming glyph has fully scrolled in: it becomes the left glyph.
            left_d  = right_q;
            blank_d = 1'b0;
            shift_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              right_d  = fifo_dout;
              state_d  = ISSUE;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state and frame fields.
  always_comb begin
    frame_valid      = (state_q == ISSUE);
    busy             = (state_q != IDLE);
    frame_left       = left_q;
    frame_right      = right_q;
    frame_shift      = shift_q;
    frame_blank_left = blank_q;
  end

endmodule

// File: tb/tb_matrix_scroll_sched.sv
// Directed bench for matrix_scroll_sched with a frame scoreboard:
// every accepted character queues its eight expected scroll frames.
module tb_matrix_scroll_sched;

  localparam int CW    = 1;
  localparam int DEPTH = 4;
  localparam int GAP   = 4;

  logic          clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          reset = 1'b0;
  logic          char_valid = 1'b0;
  logic [CW-1:0] char_data = '0;
  logic          pause = 1'b0;
  logic          frame_ready = 1'b0;
  logic          frame_done = 1'b0;

  logic          char_ready;
  logic          frame_valid;
  logic [CW-1:0] frame_left;
  logic [CW-1:0] frame_right;
  logic [2:0]    frame_shift;
  logic          frame_blank_left;
  logic          busy;
  logic [2:0]    fifo_level;

  matrix_scroll_sched #(
    .FIFO_DEPTH (DEPTH),
    .CHAR_W     (CW),
    .FRAME_GAP  (GAP)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .char_valid       (char_valid),
    .char_data        (char_data),
    .char_ready       (char_ready),
    .pause            (pause),
    .frame_valid      (frame_valid),
    .frame_ready      (frame_ready),
    .frame_done       (frame_done),
    .frame_left       (frame_left),
    .frame_right      (frame_right),
    .frame_shift      (frame_shift),
    .frame_blank_left (frame_blank_left),
    .busy             (busy),
    .fifo_level       (fifo_level)
  );

  always #5 if (clk_en) clk = ~clk;

  typedef struct {
    logic [CW-1:0] left;
    logic [CW-1:0] right;
    logic [2:0]    shift;
    logic          blank;
  } frame_t;

  frame_t        exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            fr_n = 0;
  logic [CW-1:0] m_prev = '0;
  logic          m_has = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a new glyph scrolls in behind the previous one.
  task automatic on_push(input logic [CW-1:0] c);
    frame_t f;
    for (int s = 0; s < 8; s++) begin
      f.left  = m_prev;
      f.right = c;
      f.shift = 3'(s);
      f.blank = !m_has;
      exp_q.push_back(f);
    end
    $display("push char=%0d queued_frames=%0d", c, exp_q.size());
    m_prev = c;
    m_has  = 1'b1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_prev = '0;
    m_has  = 1'b0;
  endtask

  // One clock; records a push if the handshake completed on this edge.
  task automatic tick();
    logic acc;
    acc = char_valid && char_ready;
    @(posedge clk);
    #1;
    if (acc && !reset) begin
      on_push(char_data);
      char_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!frame_valid && n < 500) begin
      tick();
      n++;
    end
    if (!frame_valid) chk("valid_timeout", 32'(frame_valid), 32'd1);
  endtask

  task automatic check_front();
    frame_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("left",  32'(frame_left), 32'(e.left));
      chk("right", 32'(frame_right), 32'(e.right));
      chk("shift", 32'(frame_shift), 32'(e.shift));
      chk("blank", 32'(frame_blank_left), 32'(e.blank));
      $display("frame %0d left=%0d right=%0d shift=%0d blank_left=%0d",
               fr_n, frame_left, frame_right, frame_shift, frame_blank_left);
      fr_n++;
    end
  endtask

  // Wait for a command, check it, accept it, and pulse done after done_dly cycles.
  task automatic serve(input int done_dly);
    int n;
    wait_valid(n);
    check_front();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("valid_after_accept", 32'(frame_valid), 32'd0);
    repeat (done_dly - 1) tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  initial begin
    int n;
    frame_t e;
    logic [CW-1:0] burst [5];
    burst[0] = 1'b0; burst[1] = 1'b1; burst[2] = 1'b1; burst[3] = 1'b0; burst[4] = 1'b1;

    // 1: asynchronous reset with the clock stopped
    #1 reset = 1'b1;
    #2;
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_blank", 32'(frame_blank_left), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ready", 32'(char_ready), 32'd1);
    chk("rst_left",  32'(frame_left), 32'd0);
    chk("rst_right", 32'(frame_right), 32'd0);
    chk("rst_shift", 32'(frame_shift), 32'd0);
    clk_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // 2: single glyph scrolls through all eight steps
    char_valid = 1'b1; char_data = 1'b1;
    tick();
    chk("t2_level_push", 32'(fifo_level), 32'd1);
    chk("t2_valid_early", 32'(frame_valid), 32'd0);
    tick();
    chk("t2_valid_latency", 32'(frame_valid), 32'd1);
    chk("t2_level_pop", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 8; i++) begin
      serve(3);
      if (i < 7) begin
        wait_valid(n);
        chk("t2_gap", 32'(n), 32'(GAP));
      end
    end
    repeat (GAP) tick();
    chk("t2_idle_busy", 32'(busy), 32'd0);
    chk("t2_idle_valid", 32'(frame_valid), 32'd0);
    chk("t2_idle_left", 32'(frame_left), 32'd1);
    chk("t2_idle_blank", 32'(frame_blank_left), 32'd0);
    chk("t2_idle_shift", 32'(frame_shift), 32'd0);

    // 3: fill the FIFO while the streamer stalls
    char_valid = 1'b1; char_data = 1'b1;
    tick();
    tick();
    chk("t3_issue", 32'(frame_valid), 32'd1);
    for (int k = 0; k < 4; k++) begin
      char_valid = 1'b1; char_data = burst[k];
      tick();
    end
    chk("t3_level_full", 32'(fifo_level), 32'd4);
    chk("t3_ready_full", 32'(char_ready), 32'd0);
    char_valid = 1'b1; char_data = burst[4];

    // 4: long stall keeps the command stable
    e = exp_q[0];
    repeat (100) begin
      tick();
      chk("t4_valid", 32'(frame_valid), 32'd1);
      chk("t4_left",  32'(frame_left), 32'(e.left));
      chk("t4_right", 32'(frame_right), 32'(e.right));
      chk("t4_shift", 32'(frame_shift), 32'(e.shift));
    end
    chk("t4_level_held", 32'(fifo_level), 32'd4);

    // 5: stray frame_done in ISSUE and GAP, and pause stretches the gap
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("t5_done_in_issue", 32'(frame_valid), 32'd1);
    serve(3);
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    pause = 1'b1;
    repeat (10) tick();
    chk("t5_paused_valid", 32'(frame_valid), 32'd0);
    pause = 1'b0;
    wait_valid(n);
    chk("t5_pause_gap", 32'(n), 32'd2);
    for (int i = 1; i < 8; i++) begin
      serve(3);
      if (i < 7) begin
        wait_valid(n);
        chk("t5_gap", 32'(n), 32'(GAP));
      end
    end
    repeat (GAP - 1) tick();
    chk("t3_level_before_pop", 32'(fifo_level), 32'd4);
    tick();
    chk("t3_level_after_pop", 32'(fifo_level), 32'd3);
    chk("t3_ready_after_pop", 32'(char_ready), 32'd1);
    chk("t3_valid_after_pop", 32'(frame_valid), 32'd1);
    tick();
    chk("t3_fifth_accepted", 32'(fifo_level), 32'd4);
    serve(3);

    // 6: reset in WAIT_DONE with two entries buffered
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6a_level", 32'(fifo_level), 32'd0);
    chk("t6a_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    char_valid = 1'b1; char_data = 1'b1; tick();
    char_valid = 1'b1; char_data = 1'b0; tick();
    char_valid = 1'b1; char_data = 1'b1; tick();
    chk("t6_level2", 32'(fifo_level), 32'd2);
    check_front();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("t6_wait_busy", 32'(busy), 32'd1);
    chk("t6_wait_valid", 32'(frame_valid), 32'd0);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_valid", 32'(frame_valid), 32'd0);
    chk("t6_rst_level", 32'(fifo_level), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ready", 32'(char_ready), 32'd1);
    chk("t6_rst_blank", 32'(frame_blank_left), 32'd1);
    chk("t6_rst_right", 32'(frame_right), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    repeat (GAP + 2) tick();
    chk("t6_done_ignored_busy", 32'(busy), 32'd0);
    chk("t6_done_ignored_valid", 32'(frame_valid), 32'd0);
    chk("t6_done_ignored_level", 32'(fifo_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
